// File: rtl/register_file.sv
// register_file: DEPTH = 2**ADDR_W general-purpose registers with two
// registered read ports and one write port.
//   CLK, RST              clock, synchronous active-high reset
//   read_en               capture new read data this edge (else hold)
//   read_register1/2      read indices (read_register2 doubles as write index)
//   destination_register  write index when regdst=1
//   regdst                write-index select
//   regwrite/regwritedata write enable and data
//   readdata1/2           registered read data (one-cycle latency)
//   write_count           committed-write counter, wraps at 2**16
// BYPASS=1 forwards same-edge write data to the reads; ZERO_REG=1 hardwires r0.
module register_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_register1,
  input  logic [ADDR_W-1:0] read_register2,
  input  logic [ADDR_W-1:0] destination_register,
  input  logic              regdst,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] regwritedata,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic [15:0]       write_count
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] wa;
  logic              commit;
  logic [DATA_W-1:0] rd1_nxt, rd2_nxt;

  assign wa     = regdst ? destination_register : read_register2;
  // Writes to r0 are dropped entirely (not stored, not counted) when it is hardwired.
  assign commit = regwrite && !((ZERO_REG != 0) && (wa == '0));

  // One flop bank per register; r0 collapses to a constant when hardwired.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      always_ff @(posedge CLK) begin
        if (RST)
          regs[i] <= '0;
        else if (commit && (wa == ADDR_W'(i)))
          regs[i] <= regwritedata;
      end
    end
  end

  // Read-data selection: zero register wins over forwarding, forwarding over storage.
  always_comb begin
    rd1_nxt = regs[read_register1];
    rd2_nxt = regs[read_register2];
    if ((BYPASS != 0) && commit && (read_register1 == wa)) rd1_nxt = regwritedata;
    if ((BYPASS != 0) && commit && (read_register2 == wa)) rd2_nxt = regwritedata;
    if ((ZERO_REG != 0) && (read_register1 == '0)) rd1_nxt = '0;
    if ((ZERO_REG != 0) && (read_register2 == '0)) rd2_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      readdata1   <= '0;
      readdata2   <= '0;
      write_count <= '0;
    end else begin
      if (read_en) begin
        readdata1 <= rd1_nxt;
        readdata2 <= rd2_nxt;
      end
      if (commit) write_count <= write_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared stimulus for the two 8-bit instances.
  logic       RST, read_en, regdst, regwrite;
  logic [1:0] ra1, ra2, dst;
  logic [7:0] wd;
  logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic [15:0] a_wc, b_wc;

  // 32-bit / 32-entry instance.
  logic        c_rst, c_ren, c_regdst, c_we;
  logic [4:0]  c_ra1, c_ra2, c_dst;
  logic [31:0] c_wd, c_rd1, c_rd2;
  logic [15:0] c_wc;

  int n_chk = 0;
  int n_fail = 0;

  register_file #(.DATA_W(8), .ADDR_W(2), .BYPASS(0), .ZERO_REG(0)) dut_a (
    .CLK(CLK), .RST(RST), .read_en(read_en), .read_register1(ra1), .read_register2(ra2),
    .destination_register(dst), .regdst(regdst), .regwrite(regwrite), .regwritedata(wd),
    .readdata1(a_rd1), .readdata2(a_rd2), .write_count(a_wc));

  register_file #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .CLK(CLK), .RST(RST), .read_en(read_en), .read_register1(ra1), .read_register2(ra2),
    .destination_register(dst), .regdst(regdst), .regwrite(regwrite), .regwritedata(wd),
    .readdata1(b_rd1), .readdata2(b_rd2), .write_count(b_wc));

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) dut_c (
    .CLK(CLK), .RST(c_rst), .read_en(c_ren), .read_register1(c_ra1), .read_register2(c_ra2),
    .destination_register(c_dst), .regdst(c_regdst), .regwrite(c_we), .regwritedata(c_wd),
    .readdata1(c_rd1), .readdata2(c_rd2), .write_count(c_wc));

  typedef struct {
    logic       rst, ren;
    logic [1:0] r1, r2, dst;
    logic       rdst, we;
    logic [7:0] wd;
    logic [7:0] a1, a2;  logic [15:0] awc;  // expected, BYPASS=0 ZERO_REG=0
    logic [7:0] b1, b2;  logic [15:0] bwc;  // expected, BYPASS=1 ZERO_REG=1
  } vec_t;

  typedef struct {
    logic [7:0] a1, a2; logic [15:0] awc;
    logic [7:0] b1, b2; logic [15:0] bwc;
  } exp_t;

  exp_t sb[$];

  typedef struct { logic [31:0] d1, d2; } cexp_t;
  cexp_t csb[$];

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the 8-bit pair, push its expectation, then pop/compare after the edge.
  task automatic drive_ab(input vec_t v, input string tag);
    exp_t e, got;
    RST = v.rst; read_en = v.ren; ra1 = v.r1; ra2 = v.r2; dst = v.dst;
    regdst = v.rdst; regwrite = v.we; wd = v.wd;
    e.a1 = v.a1; e.a2 = v.a2; e.awc = v.awc;
    e.b1 = v.b1; e.b2 = v.b2; e.bwc = v.bwc;
    sb.push_back(e);
    @(posedge CLK); #1;
    got = sb.pop_front();
    chk({tag, " a.rd1"}, 64'(a_rd1), 64'(got.a1));
    chk({tag, " a.rd2"}, 64'(a_rd2), 64'(got.a2));
    chk({tag, " a.wc"},  64'(a_wc),  64'(got.awc));
    chk({tag, " b.rd1"}, 64'(b_rd1), 64'(got.b1));
    chk({tag, " b.rd2"}, 64'(b_rd2), 64'(got.b2));
    chk({tag, " b.wc"},  64'(b_wc),  64'(got.bwc));
  endtask

  task automatic drive_c(input logic rst, input logic ren, input logic [4:0] r1, input logic [4:0] r2,
                         input logic we, input logic [4:0] d, input logic [31:0] data);
    c_rst = rst; c_ren = ren; c_ra1 = r1; c_ra2 = r2; c_regdst = 1'b1;
    c_we = we; c_dst = d; c_wd = data;
    @(posedge CLK); #1;
  endtask

  initial begin
    //            rst ren r1 r2 dst rd we wd      a1     a2     awc   b1     b2     bwc
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};
    vecs[1]  = '{0, 1, 0, 0, 3, 1, 1, 8'hA5, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1};
    vecs[2]  = '{0, 1, 3, 3, 0, 1, 0, 8'h00, 8'hA5, 8'hA5, 1, 8'hA5, 8'hA5, 1};
    vecs[3]  = '{0, 1, 1, 2, 0, 0, 1, 8'h3C, 8'h00, 8'h00, 2, 8'h00, 8'h3C, 2};
    vecs[4]  = '{0, 1, 2, 1, 0, 1, 0, 8'h00, 8'h3C, 8'h00, 2, 8'h3C, 8'h00, 2};
    vecs[5]  = '{0, 0, 0, 0, 1, 1, 1, 8'h11, 8'h3C, 8'h00, 3, 8'h3C, 8'h00, 3};
    vecs[6]  = '{0, 1, 1, 1, 1, 1, 1, 8'h77, 8'h11, 8'h11, 4, 8'h77, 8'h77, 4};
    vecs[7]  = '{0, 1, 1, 3, 0, 1, 0, 8'h00, 8'h77, 8'hA5, 4, 8'h77, 8'hA5, 4};
    vecs[8]  = '{0, 1, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 8'h00, 5, 8'h00, 8'h00, 4};
    vecs[9]  = '{0, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF, 5, 8'h00, 8'h00, 4};
    vecs[10] = '{1, 1, 1, 3, 2, 1, 1, 8'hEE, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};
    vecs[11] = '{0, 1, 2, 3, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};

    c_rst = 1; c_ren = 0; c_ra1 = 0; c_ra2 = 0; c_regdst = 1; c_we = 0; c_dst = 0; c_wd = 0;

    for (int i = 0; i < 12; i++) drive_ab(vecs[i], $sformatf("vec%0d", i));

    // Reset after three writes with a write pending on the reset edge.
    begin
      vec_t v;
      v = '{1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0};
      drive_ab(v, "rst2");
      v = '{0, 0, 0, 0, 1, 1, 1, 8'h01, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1}; drive_ab(v, "w1");
      v = '{0, 0, 0, 0, 2, 1, 1, 8'h02, 8'h00, 8'h00, 2, 8'h00, 8'h00, 2}; drive_ab(v, "w2");
      v = '{0, 0, 0, 0, 3, 1, 1, 8'h03, 8'h00, 8'h00, 3, 8'h00, 8'h00, 3}; drive_ab(v, "w3");
      v = '{1, 1, 1, 2, 3, 1, 1, 8'h99, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0}; drive_ab(v, "rstwr");
      v = '{0, 1, 1, 3, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0}; drive_ab(v, "post1");
      v = '{0, 1, 2, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0}; drive_ab(v, "post2");
    end

    // write_count wrap: 65535 writes to r1 reach FFFF, one more wraps to 0.
    RST = 0; read_en = 0; regdst = 1; dst = 1; regwrite = 1; wd = 8'h5A;
    for (int i = 0; i < 65535; i++) @(posedge CLK);
    #1;
    chk("wc.a ffff", 64'(a_wc), 64'hFFFF);
    chk("wc.b ffff", 64'(b_wc), 64'hFFFF);
    @(posedge CLK); #1;
    chk("wc.a wrap", 64'(a_wc), 64'h0);
    chk("wc.b wrap", 64'(b_wc), 64'h0);
    regwrite = 0;

    // Wide instance: fill all 32 registers, then sweep reads with a read_en gap.
    drive_c(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++) drive_c(0, 0, 0, 0, 1, 5'(k), 32'(k) * 32'h01010101);
    chk("c.wc", 64'(c_wc), 64'd32);
    begin
      cexp_t ce, cg, last;
      last.d1 = 0; last.d2 = 0;
      for (int k = 0; k < 32; k++) begin
        logic ren;
        ren = !(k == 16 || k == 17);
        if (ren) begin
          ce.d1 = 32'(k) * 32'h01010101;
          ce.d2 = 32'(31 - k) * 32'h01010101;
          last = ce;
        end else begin
          ce = last;
        end
        csb.push_back(ce);
        drive_c(0, ren, 5'(k), 5'(31 - k), 0, 0, 0);
        cg = csb.pop_front();
        chk($sformatf("c.rd1 k%0d", k), 64'(c_rd1), 64'(cg.d1));
        chk($sformatf("c.rd2 k%0d", k), 64'(c_rd2), 64'(cg.d2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
